// File: rtl/imn_stream_fetch_pkg.sv
// Shared types for the IMN stream fetch engine: FSM states and the OBI request/response bundles.
package imn_stream_fetch_pkg;

    localparam int unsigned IMN_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FLUSH
    } imn_state_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/imn_stream_fetch_if.sv
// OBI read port plus the valid/ready word stream toward the CGRA array input.
interface imn_stream_fetch_if;
    import imn_stream_fetch_pkg::*;

    obi_req_t    obi_req;
    obi_resp_t   obi_resp;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (
        output obi_req,
        input  obi_resp,
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  obi_req,
        output obi_resp,
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/imn_stream_fetch_resp_fifo.sv
// Response buffer: synchronous FIFO with flush; the head word is read straight out of flop storage.
module imn_resp_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [31:0]            push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [31:0]            head_o,
    output logic                   head_valid_o,
    output logic [$clog2(Depth):0] count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] Full = (PtrW + 1)'(Depth);

    logic [31:0]     mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != Full) || pop_ok);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_valid_o = (count_q != '0);
    assign head_o       = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/imn_stream_fetch.sv
// IMN fetch engine: issues strided 32-bit OBI reads, buffers responses and streams them out
// in request order.
module imn_stream_fetch
    import imn_stream_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = IMN_FIFO_DEPTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clr_i,
    input  logic [31:0]        base_addr_i,
    input  logic [15:0]        size_i,
    input  logic [15:0]        stride_i,
    imn_stream_fetch_if.master bus,
    output logic               busy_o,
    output logic               done_o
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(FIFO_DEPTH);

    imn_state_t      state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     size_q, stride_q;
    logic [15:0]     issued_cnt_q, issued_cnt_d;
    logic [15:0]     accepted_cnt_q, accepted_cnt_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic            req_hold_q;
    logic            zero_done_q;

    logic [CntW-1:0] fifo_count;
    logic [31:0]     fifo_head;
    logic            fifo_valid, fifo_push, fifo_pop, fifo_flush;
    logic [CntW:0]   in_use;
    logic            has_room, req, gnt_fire, rvalid, last_pop, idle_start;

    assign rvalid     = bus.obi_resp.rvalid;
    assign idle_start = (state_q == S_IDLE) && start_i;

    // Outstanding reads plus buffered words bound the FIFO fill, so a push can never overflow.
    assign in_use   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign has_room = (in_use < DepthLim);

    // A request that was not granted is held, even across a clear, since OBI forbids retraction.
    assign req = req_hold_q
               | ((state_q == S_FETCH) && (issued_cnt_q < size_q) && has_room);
    assign gnt_fire = req && bus.obi_resp.gnt;

    assign fifo_pop   = fifo_valid && bus.ready;
    assign fifo_push  = rvalid && (state_q != S_FLUSH);
    assign fifo_flush = clr_i && (state_q != S_IDLE);
    assign last_pop   = (state_q == S_DRAIN) && fifo_pop
                      && (accepted_cnt_q == size_q - 16'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && (size_i != 16'd0)) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (clr_i) begin
                    state_d = S_FLUSH;
                end else if (gnt_fire && (issued_cnt_q == size_q - 16'd1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (clr_i) begin
                    state_d = S_FLUSH;
                end else if (last_pop) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (!req && (outstanding_q == '0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d         = addr_q;
        issued_cnt_d   = issued_cnt_q;
        accepted_cnt_d = accepted_cnt_q;
        outstanding_d  = outstanding_q;
        if (idle_start) begin
            addr_d         = base_addr_i;
            issued_cnt_d   = 16'd0;
            accepted_cnt_d = 16'd0;
        end else begin
            if (gnt_fire) begin
                addr_d       = addr_q + {16'd0, stride_q};
                issued_cnt_d = issued_cnt_q + 16'd1;
            end
            if (fifo_pop) accepted_cnt_d = accepted_cnt_q + 16'd1;
        end
        unique case ({gnt_fire, rvalid})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            size_q         <= '0;
            stride_q       <= '0;
            issued_cnt_q   <= '0;
            accepted_cnt_q <= '0;
            outstanding_q  <= '0;
            req_hold_q     <= 1'b0;
            zero_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issued_cnt_q   <= issued_cnt_d;
            accepted_cnt_q <= accepted_cnt_d;
            outstanding_q  <= outstanding_d;
            req_hold_q     <= req && !bus.obi_resp.gnt;
            zero_done_q    <= idle_start && (size_i == 16'd0);
            if (idle_start) begin
                size_q   <= size_i;
                stride_q <= stride_i;
            end
        end
    end

    imn_resp_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (fifo_push),
        .push_data_i  (bus.obi_resp.rdata),
        .pop_i        (fifo_pop),
        .flush_i      (fifo_flush),
        .head_o       (fifo_head),
        .head_valid_o (fifo_valid),
        .count_o      (fifo_count)
    );

    always_comb begin
        bus.obi_req       = '0;
        bus.obi_req.req   = req;
        bus.obi_req.addr  = addr_q;
        bus.obi_req.we    = 1'b0;
        bus.obi_req.be    = req ? 4'hF : 4'h0;
        bus.obi_req.wdata = '0;
    end

    assign bus.data  = fifo_head;
    assign bus.valid = fifo_valid;
    assign busy_o    = (state_q != S_IDLE);
    // A clear in the same cycle as the final hand-off takes the flush path, so no done.
    assign done_o    = zero_done_q || (last_pop && !clr_i);

endmodule

// File: tb/tb_imn_stream_fetch.sv
// Bench for imn_stream_fetch: transaction-level model checked every cycle, plus directed literals.
module tb_imn_stream_fetch;
    import imn_stream_fetch_pkg::*;

    localparam int unsigned D = IMN_FIFO_DEPTH;

    logic        clk = 1'b0;
    logic        rst, start, clr, busy, done, gnt_en, rv_q;
    logic [31:0] base, rd_q;
    logic [15:0] size, stride;

    imn_stream_fetch_if bus();

    assign bus.obi_resp = '{gnt: gnt_en, rvalid: rv_q, rdata: rd_q};

    imn_stream_fetch #(.FIFO_DEPTH(D)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .clr_i       (clr),
        .base_addr_i (base),
        .size_i      (size),
        .stride_i    (stride),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0, n_pass = 0, n_done = 0;
    logic [31:0] seen_addr[$], seen_data[$], q[$];
    logic [31:0] exp_t1 [4] = '{32'hCAFE1000, 32'hCAFE1004, 32'hCAFE1008, 32'hCAFE100C};

    // Model state: one transfer in terms of words issued/returned/accepted
    bit          m_active = 0, m_flush = 0, m_zero_done = 0, zd_next = 0;
    bit          held_prev = 0, stall_prev = 0, pend_v = 0, idle_now, last, clr_eff, allowed;
    logic [31:0] m_base = '0, prev_addr, prev_data, pend_d;
    int unsigned m_size = 0, m_stride = 0, m_issued = 0, m_recv = 0, m_acc = 0, m_out = 0;
    logic        s_req, s_vld;
    logic [31:0] s_addr, s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    function automatic logic [31:0] word_addr(input int unsigned i);
        return m_base + 32'(i * m_stride);
    endfunction

    // Memory responder: rvalid one cycle after each grant
    initial begin
        rv_q = 1'b0;
        rd_q = '0;
        forever begin
            @(posedge clk);
            #1;
            rv_q = pend_v;
            rd_q = pend_v ? pend_d : 32'h0;
        end
    end

    // Compare process: checks DUT against the model on every cycle, then applies this cycle's events
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 0; m_flush = 0; m_zero_done = 0; held_prev = 0; stall_prev = 0;
                pend_v = 0; m_out = 0; q.delete();
            end else begin
                s_req  = bus.obi_req.req;
                s_addr = bus.obi_req.addr;
                s_vld  = bus.valid;
                s_data = bus.data;
                clr_eff = clr && (m_active || m_flush);

                if (m_active) chk("busy_active", busy, 1);
                else if (!m_flush) chk("busy_idle", busy, 0);
                else if (busy === 1'b0) begin
                    chk("flush_drained", m_out, 0);
                    m_flush = 0;
                end
                idle_now = !m_active && !m_flush;

                allowed = (m_active && m_issued < m_size && (m_out + 32'(q.size())) < D);
                if (held_prev) begin
                    chk("req_held", s_req, 1);
                    chk("addr_held", s_addr, prev_addr);
                end else if (!allowed) begin
                    chk("req_forbidden", s_req, 0);
                end

                if (stall_prev) begin
                    chk("valid_hold", s_vld, 1);
                    chk("data_hold", s_data, prev_data);
                end
                if (s_vld === 1'b1) begin
                    chk("valid_has_word", q.size() != 0, 1);
                    if (q.size() != 0) chk("data_order", s_data, q[0]);
                end

                last = 0;
                if (s_vld === 1'b1 && bus.ready) begin
                    seen_data.push_back(s_data);
                    if (q.size() != 0) void'(q.pop_front());
                    m_acc++;
                    last = m_active && (m_acc == m_size);
                end
                chk("done", done, m_zero_done || (last && !clr_eff));
                if (done === 1'b1) n_done++;

                if (s_req === 1'b1 && gnt_en) begin
                    chk("grant_addr", s_addr, word_addr(m_issued));
                    chk("grant_be", bus.obi_req.be, 4'hF);
                    chk("grant_we", bus.obi_req.we, 0);
                    seen_addr.push_back(s_addr);
                    m_issued++;
                    m_out++;
                end
                if (rv_q) begin
                    chk("rvalid_expected", m_out != 0, 1);
                    if (m_out != 0) m_out--;
                    if (!m_flush && !clr_eff) q.push_back(data_fn(word_addr(m_recv)));
                    m_recv++;
                end

                if (last) m_active = 0;
                if (clr_eff) begin
                    m_active = 0;
                    m_flush  = 1;
                    q.delete();
                end
                zd_next = 0;
                if (start && idle_now) begin
                    if (size == 16'd0) zd_next = 1;
                    else begin
                        m_active = 1; m_base = base; m_size = size; m_stride = stride;
                        m_issued = 0; m_recv = 0; m_acc = 0;
                    end
                end
                m_zero_done = zd_next;

                held_prev  = (s_req === 1'b1) && !gnt_en;
                prev_addr  = s_addr;
                stall_prev = (s_vld === 1'b1) && !bus.ready && !clr_eff;
                prev_data  = s_data;
                pend_v     = (s_req === 1'b1) && gnt_en;
                pend_d     = data_fn(s_addr);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] b, input logic [15:0] s, input logic [15:0] st);
        seen_addr.delete();
        seen_data.delete();
        n_done = 0;
        base = b; size = s; stride = st; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while ((busy !== 1'b0 || m_active || m_flush) && i < budget) begin
            cyc(1);
            i++;
        end
        chk(name, i < budget, 1);
        cyc(2);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0; gnt_en = 1'b1;
        base = '0; size = '0; stride = '0; bus.ready = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("reset_req", bus.obi_req.req, 0);
        chk("reset_valid", bus.valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        // Basic 4-word transfer
        launch(32'h1000, 16'd4, 16'd4);
        chk("t1_req_cycle1", bus.obi_req.req, 1);
        chk("t1_addr_cycle1", bus.obi_req.addr, 32'h1000);
        wait_idle("t1_timeout", 100);
        chk("t1_grants", seen_addr.size(), 4);
        chk("t1_addr3", seen_addr[3], 32'h100C);
        chk("t1_words", seen_data.size(), 4);
        for (int i = 0; i < 4; i++) if (i < seen_data.size()) chk("t1_data", seen_data[i], exp_t1[i]);
        chk("t1_done_count", n_done, 1);

        // Zero-size start
        launch(32'h1000, 16'd0, 16'd4);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_req", bus.obi_req.req, 0);
        cyc(3);
        chk("t3_done_once", n_done, 1);
        chk("t3_no_grants", seen_addr.size(), 0);

        // Backpressure: only FIFO_DEPTH reads in flight
        bus.ready = 1'b0;
        launch(32'h2000, 16'd8, 16'd4);
        cyc(50);
        chk("t2_grants_stalled", seen_addr.size(), 4);
        chk("t2_req_low", bus.obi_req.req, 0);
        chk("t2_valid_high", bus.valid, 1);
        bus.ready = 1'b1;
        wait_idle("t2_timeout", 200);
        chk("t2_words", seen_data.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < seen_data.size()) chk("t2_data", seen_data[i], 32'hCAFE2000 + 32'(4 * i));
        chk("t2_done_count", n_done, 1);

        // Address wrap and zero stride
        launch(32'hFFFF_FFFC, 16'd2, 16'd8);
        wait_idle("t4_timeout", 100);
        chk("t4_addr0", seen_addr[0], 32'hFFFF_FFFC);
        chk("t4_addr1", seen_addr[1], 32'h0000_0004);
        launch(32'h3000, 16'd3, 16'd0);
        wait_idle("t4b_timeout", 100);
        chk("t4b_grants", seen_addr.size(), 3);
        chk("t4b_addr2", seen_addr[2], 32'h3000);
        chk("t4b_data2", seen_data[2], 32'hCAFE3000);

        // Clear while a request waits for its grant
        gnt_en = 1'b0;
        launch(32'h4000, 16'd4, 16'd4);
        cyc(1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("t5_req_held", bus.obi_req.req, 1);
        chk("t5_addr_held", bus.obi_req.addr, 32'h4000);
        chk("t5_valid", bus.valid, 0);
        cyc(1);
        gnt_en = 1'b1;
        wait_idle("t5_timeout", 50);
        chk("t5_grants", seen_addr.size(), 1);
        chk("t5_words", seen_data.size(), 0);
        chk("t5_no_done", n_done, 0);
        chk("t5_busy", busy, 0);

        // Second start during a transfer is ignored
        launch(32'h5000, 16'd3, 16'd4);
        cyc(1);
        base = 32'h9000; size = 16'd6; start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_idle("t6_timeout", 100);
        chk("t6_grants", seen_addr.size(), 3);
        chk("t6_addr2", seen_addr[2], 32'h5008);
        chk("t6_words", seen_data.size(), 3);
        chk("t6_done_count", n_done, 1);

        // Reset mid-transfer, then recover
        bus.ready = 1'b0;
        launch(32'h7000, 16'd8, 16'd4);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6r_req", bus.obi_req.req, 0);
        chk("t6r_valid", bus.valid, 0);
        chk("t6r_data", bus.data, 0);
        chk("t6r_busy", busy, 0);
        chk("t6r_done", done, 0);
        bus.ready = 1'b1;
        cyc(2);
        launch(32'h6000, 16'd2, 16'd4);
        wait_idle("t6r_timeout", 100);
        chk("t6r_word0", seen_data[0], 32'hCAFE6000);
        chk("t6r_word1", seen_data[1], 32'hCAFE6004);
        chk("t6r_done_count", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
